// File: rtl/uart_apb_host_pkg.sv
// Shared constants and state types for the CoreUARTapb host controller.
package uart_apb_host_pkg;

    // CoreUARTapb register offsets
    localparam logic [4:0] AddrTxdata = 5'h00;
    localparam logic [4:0] AddrRxdata = 5'h04;
    localparam logic [4:0] AddrCtrl1  = 5'h08;
    localparam logic [4:0] AddrCtrl2  = 5'h0C;
    localparam logic [4:0] AddrStatus = 5'h10;

    // STATUS register bits
    localparam int unsigned StatTxRdy   = 0;
    localparam int unsigned StatRxRdy   = 1;
    localparam int unsigned StatParity  = 2;
    localparam int unsigned StatOverflw = 3;
    localparam int unsigned StatFraming = 4;

    // ERR_FLAGS bits
    localparam int unsigned ErrParity  = 0;
    localparam int unsigned ErrOverflw = 1;
    localparam int unsigned ErrFraming = 2;
    localparam int unsigned ErrBus     = 3;

    typedef enum logic [2:0] {
        StCfg1,
        StCfg2,
        StPoll,
        StRxRd,
        StTxWr,
        StGap
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PhIdle,
        PhSetup,
        PhAccess
    } apb_phase_e;

endpackage

// File: rtl/uart_apb_host_apb.sv
// APB initiator phase engine: IDLE -> SETUP -> ACCESS with a PREADY timeout.
// done/err/aborted are single-cycle strobes during the final ACCESS cycle.
module apb_master_phase
    import uart_apb_host_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       start,
    input  logic [4:0] addr,
    input  logic       write,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       aborted,
    output logic [7:0] rdata,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    apb_phase_e      phase_q;
    logic [TmoW-1:0] wait_q;
    logic            tmo_hit;

    // Completion and abort strobes, decoded from the current ACCESS cycle
    always_comb begin
        tmo_hit = (phase_q == PhAccess) && !PREADY && (wait_q == TmoW'(TIMEOUT - 1));
        done    = (phase_q == PhAccess) && (PREADY || tmo_hit);
        err     = ((phase_q == PhAccess) && PREADY && PSLVERR) || tmo_hit;
        aborted = tmo_hit;
        busy    = (phase_q != PhIdle);
        rdata   = PRDATA;
    end

    // Phase sequencing; address/data are latched at launch and held to completion
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            phase_q <= PhIdle;
            wait_q  <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            case (phase_q)
                PhIdle: begin
                    if (start) begin
                        phase_q <= PhSetup;
                        PSEL    <= 1'b1;
                        PADDR   <= addr;
                        PWRITE  <= write;
                        PWDATA  <= wdata;
                    end
                end
                PhSetup: begin
                    phase_q <= PhAccess;
                    PENABLE <= 1'b1;
                    wait_q  <= '0;
                end
                PhAccess: begin
                    if (done) begin
                        phase_q <= PhIdle;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: phase_q <= PhIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_apb_host.sv
// APB host for one CoreUARTapb: configures baud/format, then polls STATUS and
// bridges the TX/RX valid/ready streams to the TXDATA/RXDATA registers.
module uart_apb_host
    import uart_apb_host_pkg::*;
#(
    parameter int unsigned BAUD_VALUE = 1,
    parameter int unsigned PRG_BIT8   = 1,
    parameter int unsigned PRG_PARITY = 0,
    parameter int unsigned CONFIG_EN  = 1,
    parameter int unsigned POLL_GAP   = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic [3:0] ERR_FLAGS,
    input  logic       ERR_CLR,
    output logic       CFG_DONE
);

    localparam logic [12:0] Baud     = BAUD_VALUE[12:0];
    localparam logic [7:0]  Ctrl1Val = Baud[7:0];
    localparam logic [7:0]  Ctrl2Val = {Baud[12:8], PRG_PARITY == 2, PRG_PARITY != 0,
                                        PRG_BIT8 != 0};
    localparam int unsigned GapW     = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    ctrl_state_e     state_q;
    logic [GapW-1:0] gap_q;
    logic            cfg_done_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic [3:0]      err_q;
    logic [3:0]      err_set;

    logic            start;
    logic [4:0]      addr;
    logic            write;
    logic [7:0]      wdata;
    logic            busy;
    logic            done;
    logic            eng_err;
    logic            aborted;
    logic [7:0]      rdata;

    apb_master_phase #(
        .TIMEOUT (TIMEOUT)
    ) u_apb (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .start   (start),
        .addr    (addr),
        .write   (write),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (eng_err),
        .aborted (aborted),
        .rdata   (rdata),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    // Transfer request for the current state; each state launches once, from an idle engine
    always_comb begin
        start    = 1'b0;
        addr     = AddrStatus;
        write    = 1'b0;
        wdata    = 8'h00;
        TX_READY = 1'b0;
        case (state_q)
            StCfg1: begin
                start = !busy;
                addr  = AddrCtrl1;
                write = 1'b1;
                wdata = Ctrl1Val;
            end
            StCfg2: begin
                start = !busy;
                addr  = AddrCtrl2;
                write = 1'b1;
                wdata = Ctrl2Val;
            end
            StPoll: start = !busy;
            StRxRd: begin
                start = !busy;
                addr  = AddrRxdata;
            end
            StTxWr: begin
                // The byte is taken only when the write is actually launched
                start    = !busy && TX_VALID;
                addr     = AddrTxdata;
                write    = 1'b1;
                wdata    = TX_DATA;
                TX_READY = start;
            end
            StGap: start = (gap_q == GapW'(POLL_GAP - 1));
            default: start = 1'b0;
        endcase
    end

    // Sticky error sources: bus errors on any transfer, UART errors from STATUS reads
    always_comb begin
        err_set         = 4'b0000;
        err_set[ErrBus] = eng_err;
        if (state_q == StPoll && done && !aborted) begin
            err_set[ErrFraming:ErrParity] = rdata[StatFraming:StatParity];
        end
    end

    // Controller FSM with registered stream/flag outputs
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q    <= (CONFIG_EN != 0) ? StCfg1 : StPoll;
            gap_q      <= '0;
            cfg_done_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            err_q      <= 4'h0;
        end else begin
            if (CONFIG_EN == 0) begin
                cfg_done_q <= 1'b1;
            end
            err_q <= ERR_CLR ? 4'h0 : (err_q | err_set);
            if (rx_valid_q && RX_READY) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                StCfg1: if (done) state_q <= StCfg2;
                StCfg2: begin
                    if (done) begin
                        cfg_done_q <= 1'b1;
                        state_q    <= StPoll;
                    end
                end
                StPoll: begin
                    if (done) begin
                        if (aborted) begin
                            state_q <= StPoll;
                        end else if (rdata[StatRxRdy] && !rx_valid_q) begin
                            state_q <= StRxRd;
                        end else if (rdata[StatTxRdy] && TX_VALID) begin
                            state_q <= StTxWr;
                        end else if (POLL_GAP == 0) begin
                            state_q <= StPoll;
                        end else begin
                            state_q <= StGap;
                            gap_q   <= '0;
                        end
                    end
                end
                StRxRd: begin
                    if (done) begin
                        if (!aborted) begin
                            rx_data_q  <= rdata;
                            rx_valid_q <= 1'b1;
                        end
                        state_q <= StPoll;
                    end
                end
                StTxWr: begin
                    // Leave on completion, or without a transfer if the byte was withdrawn
                    if (done || (!busy && !TX_VALID)) begin
                        state_q <= StPoll;
                    end
                end
                StGap: begin
                    if (gap_q == GapW'(POLL_GAP - 1)) begin
                        state_q <= StPoll;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= StPoll;
            endcase
        end
    end

    assign RX_DATA   = rx_data_q;
    assign RX_VALID  = rx_valid_q;
    assign ERR_FLAGS = err_q;
    assign CFG_DONE  = cfg_done_q;

endmodule

// File: tb/tb_uart_apb_host.sv
// Directed bench for uart_apb_host with a behavioural CoreUARTapb responder.
module tb_uart_apb_host;
    import uart_apb_host_pkg::*;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic [4:0] PADDR;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_VALID = 1'b0;
    logic       TX_READY;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY = 1'b0;
    logic [3:0] ERR_FLAGS;
    logic       ERR_CLR = 1'b0;
    logic       CFG_DONE;

    always #5 PCLK = ~PCLK;

    uart_apb_host #(
        .BAUD_VALUE (32'h123),
        .PRG_BIT8   (1),
        .PRG_PARITY (2),
        .CONFIG_EN  (1),
        .POLL_GAP   (4),
        .TIMEOUT    (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESETN   (PRESETN),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .TX_READY  (TX_READY),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .RX_READY  (RX_READY),
        .ERR_FLAGS (ERR_FLAGS),
        .ERR_CLR   (ERR_CLR),
        .CFG_DONE  (CFG_DONE)
    );

    typedef struct {
        logic [4:0] addr;
        logic       wr;
        logic [7:0] data;
        int         acc;
        logic       cfg;
    } xfer_t;

    xfer_t      log_q[$];
    logic [7:0] status_v = 8'h00;
    logic [7:0] rxbyte_v = 8'h00;
    int         wait_n = 0;
    int         rx_reads = 0;
    int         tx_writes = 0;
    int         txrdy_pulses = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
        #1;
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (log_q.size() >= n) break;
            tick();
        end
        check(tag, log_q.size() >= n, 1);
    endtask

    // Responder: PREADY held low for wait_n ACCESS cycles, then each completion is logged
    initial begin
        int         acc_n;
        logic [4:0] setup_addr;
        xfer_t      e;
        acc_n      = 0;
        setup_addr = '0;
        PREADY     = 1'b1;
        PRDATA     = 8'h00;
        PSLVERR    = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PSEL && !PENABLE) setup_addr = PADDR;
            if (PSEL && PENABLE) acc_n++;
            else acc_n = 0;
            PREADY = !(PSEL && PENABLE) || (acc_n > wait_n);
            PRDATA = (PADDR == AddrStatus) ? status_v :
                     (PADDR == AddrRxdata) ? rxbyte_v : 8'h00;
            if (PSEL && PENABLE && PREADY) begin
                check("apb_addr_stable", PADDR, setup_addr);
                e.addr = PADDR;
                e.wr   = PWRITE;
                e.data = PWRITE ? PWDATA : PRDATA;
                e.acc  = acc_n;
                e.cfg  = CFG_DONE;
                log_q.push_back(e);
                if (!PWRITE && PADDR == AddrRxdata) rx_reads++;
                if (PWRITE && PADDR == AddrTxdata) tx_writes++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge PCLK);
            #2;
            if (TX_READY) txrdy_pulses++;
        end
    end

    initial begin
        int base;
        int p0;
        int n0;
        int cnt;
        bit seen;

        // Reset
        repeat (3) tick();
        check("rst_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, TX_READY, RX_VALID,
                              RX_DATA, ERR_FLAGS, CFG_DONE}, 32'h0);
        PRESETN = 1'b1;

        // Configuration: CTRL1 = 0x23, CTRL2 = {5'h01, odd=1, par_en=1, bit8=1} = 0x0F
        wait_log("cfg_writes_seen", 2, 50);
        check("cfg1_addr", log_q[0].addr, AddrCtrl1);
        check("cfg1_data", {log_q[0].wr, log_q[0].data}, {1'b1, 8'h23});
        check("cfg2_addr", log_q[1].addr, AddrCtrl2);
        check("cfg2_data", {log_q[1].wr, log_q[1].data}, {1'b1, 8'h0F});
        check("cfg_done_low_during_cfg", {log_q[0].cfg, log_q[1].cfg}, 2'b00);
        tick();
        check("cfg_done", CFG_DONE, 1);

        // TX: single byte 0xA5
        status_v = 8'h01;
        TX_DATA  = 8'hA5;
        TX_VALID = 1'b1;
        base     = tx_writes;
        p0       = txrdy_pulses;
        seen     = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (TX_READY) begin
                @(posedge PCLK);
                #1;
                TX_VALID = 1'b0;
                seen     = 1;
                break;
            end
        end
        check("tx_ready_seen", seen, 1);
        for (int i = 0; i < 50 && tx_writes == base; i++) tick();
        check("tx_write_done", tx_writes - base, 1);
        check("tx_write_addr", log_q[log_q.size()-1].addr, AddrTxdata);
        check("tx_write_data", log_q[log_q.size()-1].data, 8'hA5);
        repeat (40) tick();
        check("tx_single_write", tx_writes - base, 1);
        check("tx_ready_pulses", txrdy_pulses - p0, 1);

        // RX backpressure while TX keeps flowing
        status_v = 8'h03;
        rxbyte_v = 8'h5A;
        TX_DATA  = 8'h3C;
        TX_VALID = 1'b1;
        base     = tx_writes;
        p0       = rx_reads;
        repeat (150) tick();
        check("rx_single_read", rx_reads - p0, 1);
        check("rx_valid_held", RX_VALID, 1);
        check("rx_data", RX_DATA, 8'h5A);
        check("tx_continues", (tx_writes - base) >= 2, 1);
        rxbyte_v = 8'h11;
        repeat (20) tick();
        check("rx_data_stable", RX_DATA, 8'h5A);
        TX_VALID = 1'b0;
        status_v = 8'h00;
        RX_READY = 1'b1;
        @(posedge PCLK);
        #1;
        RX_READY = 1'b0;
        check("rx_valid_cleared", RX_VALID, 0);
        RX_READY = 1'b1;
        repeat (30) tick();
        RX_READY = 1'b0;

        // Errors from STATUS, and clear-vs-set priority
        status_v = 8'h1C;
        for (int i = 0; i < 100 && ERR_FLAGS != 4'h7; i++) tick();
        check("err_status_set", ERR_FLAGS, 4'h7);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (PSEL && PENABLE && PADDR == AddrStatus) begin
                ERR_CLR = 1'b1;
                @(posedge PCLK);
                #1;
                ERR_CLR = 1'b0;
                seen    = 1;
                break;
            end
        end
        check("err_clr_aligned", seen, 1);
        check("err_clr_priority", ERR_FLAGS, 4'h0);
        for (int i = 0; i < 100 && ERR_FLAGS != 4'h7; i++) tick();
        check("err_set_again", ERR_FLAGS, 4'h7);
        status_v = 8'h00;
        repeat (15) tick();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        tick();
        check("err_cleared", ERR_FLAGS, 4'h0);

        // Wait states: 3 low cycles extend ACCESS to 4 cycles, no error
        for (int i = 0; i < 50 && PSEL; i++) tick();
        wait_n = 3;
        n0     = log_q.size();
        wait_log("wait_xfer_seen", n0 + 1, 60);
        check("wait_access_len", log_q[n0].acc, 4);
        check("wait_no_err", ERR_FLAGS[ErrBus], 0);

        // Timeout: abort after 16 ACCESS cycles, bus error, polling resumes
        for (int i = 0; i < 50 && PSEL; i++) tick();
        wait_n = 20;
        for (int i = 0; i < 50 && !(PSEL && PENABLE); i++) tick();
        cnt = 0;
        while (PSEL && PENABLE && cnt < 40) begin
            cnt++;
            tick();
        end
        wait_n = 0;
        check("tmo_access_len", cnt, 16);
        check("tmo_psel_drop", PSEL, 0);
        check("tmo_err_bus", ERR_FLAGS, 4'h8);
        n0 = log_q.size();
        wait_log("tmo_poll_resumes", n0 + 1, 60);
        check("tmo_poll_addr", log_q[n0].addr, AddrStatus);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;

        // Reset in the middle of a TX write ACCESS
        for (int i = 0; i < 50 && PSEL; i++) tick();
        wait_n   = 5;
        status_v = 8'h01;
        TX_DATA  = 8'h77;
        TX_VALID = 1'b1;
        seen     = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (PSEL && PENABLE && PWRITE && PADDR == AddrTxdata) begin
                seen = 1;
                break;
            end
        end
        check("rst_tx_access_seen", seen, 1);
        PRESETN = 1'b0;
        #1;
        check("rst_async_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, TX_READY, RX_VALID,
                                    RX_DATA, ERR_FLAGS, CFG_DONE}, 32'h0);
        TX_VALID = 1'b0;
        wait_n   = 0;
        status_v = 8'h00;
        n0       = log_q.size();
        repeat (2) tick();
        PRESETN = 1'b1;
        wait_log("rst_recfg_seen", n0 + 1, 50);
        check("rst_recfg_addr", log_q[n0].addr, AddrCtrl1);
        check("rst_recfg_data", {log_q[n0].wr, log_q[n0].data}, {1'b1, 8'h23});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
